// File: rtl/tri_bus_pkg.sv
// Shared types and defaults for the tri-state bus reader.
package tri_bus_pkg;

    // Reader FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_e;

    // Default capture FIFO depth (entries, power of two).
    localparam int unsigned DEFAULT_DEPTH = 4;

endpackage

// File: rtl/tri_bus_fifo.sv
// First-word-fall-through capture FIFO; head is visible with no extra cycle.
module tri_bus_fifo #(
    parameter int unsigned W     = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic                       push,
    input  logic [W-1:0]               wr_data,
    input  logic                       pop,
    output logic [W-1:0]               rd_data,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_c, empty_c, do_push_c, do_pop_c;

    // Occupancy flags, qualified push/pop and next pointer/count values.
    always_comb begin
        full_c    = (count_q == CW'(DEPTH));
        empty_c   = (count_q == '0);
        do_push_c = push && !full_c && rstN;
        do_pop_c  = pop && !empty_c;
        wr_ptr_d  = wr_ptr_q + AW'(do_push_c);
        rd_ptr_d  = rd_ptr_q + AW'(do_pop_c);
        count_d   = count_q + CW'(do_push_c) - CW'(do_pop_c);
    end

    // Pointer and count registers; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Head outputs; data reads as zero while empty.
    always_comb begin
        valid   = !empty_c;
        rd_data = empty_c ? '0 : mem_q[rd_ptr_q];
        count   = count_q;
    end

endmodule

// File: rtl/tri_bus_reader.sv
// Round-robin reader of a shared tri-state bus into a capture FIFO.
// Optional macro TRI_BUS_SRC_ID_EN adds out_src (granted driver index per entry).
module tri_bus_reader
    import tri_bus_pkg::*;
#(
    parameter int unsigned N       = 4,
    parameter int unsigned DRIVERS = 2,
    parameter int unsigned DEPTH   = DEFAULT_DEPTH
) (
    input  logic                         clk,
    input  logic                         rstN,
    input  logic [DRIVERS-1:0]           req,
    output logic [DRIVERS-1:0]           drv_en,
    input  tri logic [N-1:0]             bus,
    output logic [N-1:0]                 out_data,
    output logic                         out_valid,
    input  logic                         out_ready
`ifdef TRI_BUS_SRC_ID_EN
    ,
    output logic [$clog2(DRIVERS)-1:0]   out_src
`endif
);

    localparam int unsigned IW = $clog2(DRIVERS);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
`ifdef TRI_BUS_SRC_ID_EN
    localparam int unsigned EW = N + IW;
`else
    localparam int unsigned EW = N;
`endif

    state_e             state_q, state_d;
    logic [DRIVERS-1:0] drv_en_q, drv_en_d;
    logic [IW-1:0]      grant_q, grant_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]      pick_c;
    logic               push_c;
    logic [EW-1:0]      wr_data_c;
    logic [EW-1:0]      rd_data;
    logic [CW-1:0]      fifo_count;

    // Round-robin pick: first requester at or after rr_ptr, wrapping upward.
    always_comb begin : arb
        logic        found;
        int unsigned j;
        found  = 1'b0;
        j      = 0;
        pick_c = rr_ptr_q;
        for (int unsigned k = 0; k < DRIVERS; k++) begin
            j = (32'(rr_ptr_q) + k) % DRIVERS;
            if (!found && req[IW'(j)]) begin
                pick_c = IW'(j);
                found  = 1'b1;
            end
        end
    end

    // Next-state, grant, round-robin pointer and capture strobe.
    always_comb begin
        state_d  = state_q;
        drv_en_d = '0;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        push_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if ((|req) && (fifo_count < CW'(DEPTH))) begin
                    state_d          = GRANT;
                    grant_d          = pick_c;
                    drv_en_d[pick_c] = 1'b1;
                end
            end
            GRANT: begin
                push_c   = 1'b1;
                rr_ptr_d = (grant_q == IW'(DRIVERS - 1)) ? '0 : grant_q + IW'(1);
                state_d  = TURN;
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and registered driver enable; reset aborts any transfer in flight.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q  <= IDLE;
            drv_en_q <= '0;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            drv_en_q <= drv_en_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef TRI_BUS_SRC_ID_EN
    // FIFO entry carries the bus word plus the driver it came from.
    always_comb wr_data_c = {grant_q, bus};
`else
    // FIFO entry carries only the bus word.
    always_comb wr_data_c = bus;
`endif

    tri_bus_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstN    (rstN),
        .push    (push_c),
        .wr_data (wr_data_c),
        .pop     (out_ready),
        .rd_data (rd_data),
        .valid   (out_valid),
        .count   (fifo_count)
    );

    // Output mapping from registered state and the FIFO head.
    always_comb begin
        drv_en   = drv_en_q;
        out_data = rd_data[N-1:0];
`ifdef TRI_BUS_SRC_ID_EN
        out_src  = rd_data[N +: IW];
`endif
    end

endmodule

// File: tb/tb_tri_bus_reader.sv
// Self-checking bench for tri_bus_reader against a transaction-level model.
module tb_tri_bus_reader;

    localparam int N       = 4;
    localparam int DRIVERS = 2;
    localparam int DEPTH   = 4;
    localparam int IW      = 1;

    logic               clk = 1'b0;
    logic               rstN;
    logic [DRIVERS-1:0] req;
    logic [DRIVERS-1:0] drv_en;
    tri logic [N-1:0]   bus;
    logic [N-1:0]       out_data;
    logic               out_valid;
    logic               out_ready;
`ifdef TRI_BUS_SRC_ID_EN
    logic [IW-1:0]      out_src;
`endif

    logic [N-1:0] drv_data [DRIVERS];

    int total = 0;
    int bad   = 0;

    // Model: transfer progress (0 waiting, 1 driver on bus, 2 gap), fairness pointer, FIFO contents.
    int           m_phase = 0;
    int           m_grant = 0;
    int           m_rr    = 0;
    logic [N-1:0] m_q [$];
    int           m_src [$];

    always #5 clk = ~clk;

    function automatic int first_idx(logic [DRIVERS-1:0] v);
        int r = 0;
        for (int i = DRIVERS - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    assign bus = (drv_en != '0) ? drv_data[first_idx(drv_en)] : {N{1'bz}};

    tri_bus_reader #(.N(N), .DRIVERS(DRIVERS), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstN      (rstN),
        .req       (req),
        .drv_en    (drv_en),
        .bus       (bus),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef TRI_BUS_SRC_ID_EN
        ,
        .out_src   (out_src)
`endif
    );

    function automatic int m_pick();
        for (int k = 0; k < DRIVERS; k++)
            if (req[(m_rr + k) % DRIVERS]) return (m_rr + k) % DRIVERS;
        return m_rr;
    endfunction

    function automatic logic [DRIVERS-1:0] m_en();
        logic [DRIVERS-1:0] e = '0;
        if (m_phase == 1) e[m_grant] = 1'b1;
        return e;
    endfunction

    function automatic logic m_valid();
        return m_q.size() > 0;
    endfunction

    function automatic logic [N-1:0] m_head();
        return (m_q.size() > 0) ? m_q[0] : '0;
    endfunction

    // Advance the model by one clock using the inputs present before the edge.
    task automatic model_step();
        bit           do_pop;
        bit           do_push;
        logic [N-1:0] pd;
        int           g;
        int           np;
        if (!rstN) begin
            m_phase = 0;
            m_rr    = 0;
            m_q.delete();
            m_src.delete();
        end else begin
            do_pop  = (m_q.size() > 0) && out_ready;
            do_push = (m_phase == 1);
            pd      = drv_data[m_grant];
            g       = m_grant;
            np      = 0;
            if (m_phase == 0) begin
                if (req != '0 && m_q.size() < DEPTH) begin
                    np      = 1;
                    m_grant = m_pick();
                end
            end else if (m_phase == 1) begin
                np   = 2;
                m_rr = (m_grant + 1) % DRIVERS;
            end
            if (do_pop) begin
                void'(m_q.pop_front());
                void'(m_src.pop_front());
            end
            if (do_push) begin
                m_q.push_back(pd);
                m_src.push_back(g);
            end
            m_phase = np;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstN = 1'b0; req = '0; out_ready = 1'b0;
        cycle(); cycle();
        total++; if (drv_en !== '0) begin bad++; $display("FAIL reset_drv_en got=%b want=0", drv_en); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", out_data); end
        rstN = 1'b1;
    endtask

    task automatic test_single();
        drv_data[0] = N'(3 + 5);
        drv_data[1] = 4'h0;
        req = 2'b01; out_ready = 1'b0;
        cycle();
        total++; if (drv_en !== 2'b01) begin bad++; $display("FAIL single_grant drv_en got=%b want=01", drv_en); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b want=0", out_valid); end
        req = 2'b00;
        cycle();
        total++; if (drv_en !== 2'b00) begin bad++; $display("FAIL single_turn drv_en got=%b want=00", drv_en); end
        total++; if (out_valid !== 1'b1 || out_data !== 4'd8) begin
            bad++; $display("FAIL single_capture got=%b/%h want=1/8", out_valid, out_data); end
        cycle();
        out_ready = 1'b1;
        cycle();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_pop valid got=%b want=0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_alternate();
        int seq [$];
        rstN = 1'b0; cycle(); rstN = 1'b1;
        req = 2'b11; out_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            drv_data[0] = N'($urandom); drv_data[1] = N'($urandom);
            cycle();
            total++; if (drv_en !== m_en() || out_valid !== m_valid() || out_data !== m_head()) begin
                bad++; $display("FAIL alt_cycle%0d got=%b/%b/%h want=%b/%b/%h", c, drv_en, out_valid, out_data, m_en(), m_valid(), m_head()); end
            total++; if (drv_en === 2'b11) begin bad++; $display("FAIL alt_onehot got=%b want=not 11", drv_en); end
            if (drv_en != '0) seq.push_back(first_idx(drv_en));
        end
        total++; if (seq.size() != 8) begin bad++; $display("FAIL alt_rate grants got=%0d want=8", seq.size()); end
        for (int i = 0; i < seq.size(); i++) begin
            total++; if (seq[i] != i % 2) begin bad++; $display("FAIL alt_order idx%0d got=%0d want=%0d", i, seq[i], i % 2); end
        end
        req = '0;
    endtask

    task automatic test_full();
        int g = 0;
        rstN = 1'b0; cycle(); rstN = 1'b1;
        req = DRIVERS'($urandom_range(1, 3)); out_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            drv_data[0] = N'($urandom); drv_data[1] = N'($urandom);
            cycle();
            total++; if (drv_en !== m_en() || out_data !== m_head()) begin
                bad++; $display("FAIL full_cycle%0d got=%b/%h want=%b/%h", c, drv_en, out_data, m_en(), m_head()); end
            if (drv_en != '0) g++;
        end
        total++; if (g != 4) begin bad++; $display("FAIL full_grants got=%0d want=4", g); end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        total++; if (drv_en !== 2'b00) begin bad++; $display("FAIL full_pop_no_grant got=%b want=00", drv_en); end
        g = 0;
        for (int c = 0; c < 9; c++) begin
            cycle();
            total++; if (drv_en !== m_en() || out_data !== m_head()) begin
                bad++; $display("FAIL full_after_pop%0d got=%b/%h want=%b/%h", c, drv_en, out_data, m_en(), m_head()); end
            if (drv_en != '0) g++;
        end
        total++; if (g != 1) begin bad++; $display("FAIL full_one_more got=%0d want=1", g); end
        req = '0;
    endtask

    task automatic test_reset_grant();
        rstN = 1'b0; cycle(); rstN = 1'b1;
        drv_data[0] = 4'h5; req = 2'b01; out_ready = 1'b0;
        cycle();
        total++; if (drv_en !== 2'b01) begin bad++; $display("FAIL rg_grant got=%b want=01", drv_en); end
        rstN = 1'b0;
        cycle();
        total++; if (drv_en !== 2'b00 || out_valid !== 1'b0) begin
            bad++; $display("FAIL rg_abort got=%b/%b want=00/0", drv_en, out_valid); end
        rstN = 1'b1; req = '0;
        for (int c = 0; c < 3; c++) cycle();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rg_no_capture valid got=%b want=0", out_valid); end
    endtask

    task automatic test_push_pop();
        bit hit = 0;
        int pops = 0;
        rstN = 1'b0; cycle(); rstN = 1'b1;
        req = 2'b01; out_ready = 1'b0;
        for (int c = 0; c < 30 && !hit; c++) begin
            drv_data[0] = N'($urandom);
            cycle();
            total++; if (drv_en !== m_en() || out_data !== m_head()) begin
                bad++; $display("FAIL pp_fill%0d got=%b/%h want=%b/%h", c, drv_en, out_data, m_en(), m_head()); end
            if (m_q.size() == 2 && m_phase == 1) hit = 1;
        end
        total++; if (!hit) begin bad++; $display("FAIL pp_timeout got=no grant at two entries want=grant"); end
        req = '0; out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== m_head()) begin
            bad++; $display("FAIL pp_same_cycle got=%b/%h want=1/%h", out_valid, out_data, m_head()); end
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (out_valid) pops++;
            total++; if (out_valid !== m_valid() || out_data !== m_head()) begin
                bad++; $display("FAIL pp_drain%0d got=%b/%h want=%b/%h", c, out_valid, out_data, m_valid(), m_head()); end
            cycle();
        end
        total++; if (pops != 2) begin bad++; $display("FAIL pp_count got=%0d want=2", pops); end
        out_ready = 1'b0;
    endtask

    task automatic test_src();
        rstN = 1'b0; cycle(); rstN = 1'b1;
        drv_data[1] = 4'hA; drv_data[0] = 4'h3;
        req = 2'b10; out_ready = 1'b0;
        cycle();
        req = '0;
        cycle();
        total++; if (out_valid !== 1'b1 || out_data !== 4'hA) begin
            bad++; $display("FAIL src_data got=%b/%h want=1/a", out_valid, out_data); end
`ifdef TRI_BUS_SRC_ID_EN
        total++; if (out_src !== 1'b1) begin bad++; $display("FAIL src_id got=%0d want=1", out_src); end
`endif
        cycle();
        out_ready = 1'b1; cycle(); out_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rstN        = ($urandom_range(0, 59) != 0);
            req         = DRIVERS'($urandom);
            out_ready   = ($urandom_range(0, 2) == 0);
            drv_data[0] = N'($urandom);
            drv_data[1] = N'($urandom);
            cycle();
            total++; if (drv_en !== m_en() || out_valid !== m_valid() || out_data !== m_head()) begin
                bad++; $display("FAIL rand_cycle%0d got=%b/%b/%h want=%b/%b/%h", c, drv_en, out_valid, out_data, m_en(), m_valid(), m_head()); end
`ifdef TRI_BUS_SRC_ID_EN
            if (m_q.size() > 0) begin
                total++; if (int'(out_src) != m_src[0]) begin
                    bad++; $display("FAIL rand_src%0d got=%0d want=%0d", c, out_src, m_src[0]); end
            end
`endif
        end
        rstN = 1'b1; req = '0; out_ready = 1'b0;
    endtask

    initial begin
        rstN = 1'b0; req = '0; out_ready = 1'b0;
        drv_data[0] = '0; drv_data[1] = '0;
        #1;
        test_reset();
        test_single();
        test_alternate();
        test_full();
        test_reset_grant();
        test_push_pop();
        test_src();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
